ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receive-only front end. It samples the asynchronous `ps2_clock`/`ps2_data` lines in the system clock domain, deserialises 11-bit device-to-host frames and checks them. Each good byte is emitted as an 8-bit scancode with a one-cycle `valid` strobe. It sits under the keyboard controller, which interprets make/break codes (0xF0, 0xE0 prefixes are passed through raw); this block does no code translation and never drives the PS/2 lines.

---
 rtl/ps2_keyboard_rx_pkg.sv | 16 +
 rtl/ps2_keyboard_rx_if.sv | 12 +
 rtl/ps2_sync_filter.sv | 70 +++++++
 rtl/ps2_keyboard_rx.sv | 114 +++++++++++
 tb/tb_ps2_keyboard_rx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg
// Shared types and helpers for the PS/2 keyboard receiver.
//   rx_state_e   : frame receiver state encoding
//   parity_odd() : odd-parity check over a data byte plus its parity bit
package ps2_keyboard_rx_pkg;

  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_FRAME = 1'b1
  } rx_state_e;

  function automatic logic parity_odd(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if
// Link between the PS/2 line conditioner and the frame receiver.
//   data : synchronised ps2_data, aligned with fall
//   fall : one-cycle pulse on each filtered ps2_clock falling edge
// master = conditioner (drives), slave = frame receiver (consumes).
interface ps2_keyboard_rx_if;
  logic data;
  logic fall;

  modport master (output data, output fall);
  modport slave  (input  data, input  fall);
endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter
// Two-flop synchronisers on both PS/2 lines, a glitch filter on the clock
// line and falling-edge detection of the filtered clock.
//   clock     : system clock
//   reset     : asynchronous active-low reset
//   ps2_clock : raw PS/2 clock line
//   ps2_data  : raw PS/2 data line
//   link      : master side; synchronised data + filtered falling-edge pulse
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clock,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master link
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic          clk_meta_q, clk_sync_q;
  logic          dat_meta_q, dat_sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic          dat_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the FILTER_LEN-th consecutive disagreeing sample;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (clk_sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = ~level_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      level_q    <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
      dat_q      <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clock;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      fall_q     <= fall_d;
      // Captured in the same cycle the edge is decided so data stays aligned with fall.
      dat_q      <= dat_sync_q;
    end
  end

  assign link.data = dat_q;
  assign link.fall = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// Receive-only PS/2 keyboard front end: deserialises 11-bit device-to-host
// frames, checks odd parity and stop bit, emits good bytes with a strobe.
//   clock     : system clock (50 MHz)
//   reset     : asynchronous active-low reset
//   ps2_clock : raw PS/2 clock line
//   ps2_data  : raw PS/2 data line
//   scancode  : last good byte, held until the next good byte
//   valid     : one-cycle strobe marking a new scancode
//
// state    | meaning
// RX_IDLE  | bit counter 0, waiting for a start bit (data 0 on a fall)
// RX_FRAME | collecting D0..D7, parity, stop; timeout armed
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       valid
);

  localparam int       FRAME_LEN  = 11;
  localparam logic     STOP_LEVEL = 1'b1;
  localparam int       PARITY_IDX = FRAME_LEN - 2;
  localparam int       STOP_IDX   = FRAME_LEN - 1;
  localparam int       TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  ps2_keyboard_rx_if link ();

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clock     (clock),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .link      (link)
  );

  rx_state_e     state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    scancode_q;
  logic          valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      scancode_q <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          tmo_q <= '0;
          // A start bit sampled as 1 is not a frame; stay idle.
          if (link.fall && !link.data) begin
            state_q   <= RX_FRAME;
            bit_cnt_q <= 4'd1;
            tmo_q     <= TMO_LOAD;
          end
        end
        RX_FRAME: begin
          if (link.fall) begin
            tmo_q <= TMO_LOAD;
            if (bit_cnt_q == 4'(STOP_IDX)) begin
              state_q   <= RX_IDLE;
              bit_cnt_q <= 4'd0;
              tmo_q     <= '0;
              if (parity_odd(shift_q, parity_q) && (link.data == STOP_LEVEL)) begin
                scancode_q <= shift_q;
                valid_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(PARITY_IDX)) begin
                parity_q <= link.data;
              end else begin
                // LSB first: shift in at the top so D0 ends up in bit 0.
                shift_q <= {link.data, shift_q[7:1]};
              end
            end
          end else if (tmo_q == '0) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 4'd0;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        default: begin
          state_q   <= RX_IDLE;
          bit_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign scancode = scancode_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
// Directed bench for ps2_keyboard_rx. The PS/2 bit period is scaled down
// (HALF system cycles per clock phase) and the timeout shortened to match,
// so the whole run stays short.
module tb_ps2_keyboard_rx;

  localparam int FILT = 8;
  localparam int TMO  = 600;
  localparam int HALF = 40;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] scancode;
  logic       valid;

  always #5 clock = ~clock;

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .scancode  (scancode),
    .valid     (valid)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe recorder: every valid cycle seen, with the byte and cycle stamp.
  logic [7:0] codes[$];
  int         vcycs[$];
  always @(negedge clock) begin
    if (valid === 1'b1) begin
      codes.push_back(scancode);
      vcycs.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;
  int stop_cyc = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives the first nbits of a frame. glitch_bit >= 0 inserts a 3-cycle low
  // pulse on ps2_clock in the high phase preceding that bit's falling edge.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic flip_par,
                           input logic stop, input int glitch_bit);
    logic [10:0] f;
    f = {stop, (~(^b)) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        ps2_clock = 1'b0;
        wait_cyc(3);
        ps2_clock = 1'b1;
        wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clock = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(HALF);
      ps2_clock = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    wait_cyc(3);
    total++;
    if (scancode !== 8'h00) begin
      bad++; $display("FAIL reset_scancode: got %h want 00", scancode);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    reset = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_single;
    int base, n, lat;
    logic [7:0] got;
    base = codes.size();
    send_bits(8'h1C, 11, 1'b0, 1'b1, -1);
    wait_cyc(20);
    n   = codes.size() - base;
    got = (n > 0) ? codes[base] : 8'hxx;
    lat = (n > 0) ? vcycs[base] - stop_cyc : -1;
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL single_count: got %0d want 1", n);
    end
    total++;
    if (got !== 8'h1C) begin
      bad++; $display("FAIL single_code: got %h want 1c", got);
    end
    total++;
    if (lat < FILT + 3 || lat > FILT + 5) begin
      bad++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, FILT + 3, FILT + 5);
    end
    wait_cyc(200);
    total++;
    if (scancode !== 8'h1C) begin
      bad++; $display("FAIL single_hold: got %h want 1c", scancode);
    end
    total++;
    if ((codes.size() - base) !== 1) begin
      bad++; $display("FAIL single_no_extra: got %0d want 1", codes.size() - base);
    end
  endtask

  task automatic test_back_to_back;
    int base, n;
    logic [7:0] g0, g1;
    base = codes.size();
    send_bits(8'hF0, 11, 1'b0, 1'b1, -1);
    send_bits(8'h1C, 11, 1'b0, 1'b1, -1);
    wait_cyc(20);
    n  = codes.size() - base;
    g0 = (n > 0) ? codes[base] : 8'hxx;
    g1 = (n > 1) ? codes[base + 1] : 8'hxx;
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", n);
    end
    total++;
    if (g0 !== 8'hF0) begin
      bad++; $display("FAIL b2b_first: got %h want f0", g0);
    end
    total++;
    if (g1 !== 8'h1C) begin
      bad++; $display("FAIL b2b_second: got %h want 1c", g1);
    end
  endtask

  task automatic test_bad_frames;
    int base, n;
    logic [7:0] got;
    base = codes.size();
    send_bits(8'h5A, 11, 1'b1, 1'b1, -1);
    wait_cyc(20);
    total++;
    if ((codes.size() - base) !== 0) begin
      bad++; $display("FAIL parity_count: got %0d want 0", codes.size() - base);
    end
    total++;
    if (scancode !== 8'h1C) begin
      bad++; $display("FAIL parity_hold: got %h want 1c", scancode);
    end
    send_bits(8'h33, 11, 1'b0, 1'b0, -1);
    wait_cyc(20);
    total++;
    if ((codes.size() - base) !== 0) begin
      bad++; $display("FAIL stop_count: got %0d want 0", codes.size() - base);
    end
    total++;
    if (scancode !== 8'h1C) begin
      bad++; $display("FAIL stop_hold: got %h want 1c", scancode);
    end
    send_bits(8'h66, 11, 1'b0, 1'b1, -1);
    wait_cyc(20);
    n   = codes.size() - base;
    got = (n > 0) ? codes[base] : 8'hxx;
    total++;
    if (n !== 1 || got !== 8'h66) begin
      bad++; $display("FAIL recover_after_bad: got n=%0d code=%h want n=1 code=66", n, got);
    end
  endtask

  task automatic test_glitch;
    int base, n;
    logic [7:0] got;
    base = codes.size();
    ps2_clock = 1'b0;
    wait_cyc(3);
    ps2_clock = 1'b1;
    wait_cyc(30);
    send_bits(8'h29, 11, 1'b0, 1'b1, 5);
    wait_cyc(20);
    n   = codes.size() - base;
    got = (n > 0) ? codes[base] : 8'hxx;
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL glitch_count: got %0d want 1", n);
    end
    total++;
    if (got !== 8'h29) begin
      bad++; $display("FAIL glitch_code: got %h want 29", got);
    end
  endtask

  task automatic test_timeout;
    int base, n;
    logic [7:0] got;
    base = codes.size();
    send_bits(8'h1D, 5, 1'b0, 1'b1, -1);
    wait_cyc(TMO + 120);
    send_bits(8'h5A, 11, 1'b0, 1'b1, -1);
    wait_cyc(20);
    n   = codes.size() - base;
    got = (n > 0) ? codes[base] : 8'hxx;
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL timeout_count: got %0d want 1", n);
    end
    total++;
    if (got !== 8'h5A) begin
      bad++; $display("FAIL timeout_code: got %h want 5a", got);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base, n;
    logic [7:0] got;
    base = codes.size();
    send_bits(8'h1D, 5, 1'b0, 1'b1, -1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (scancode !== 8'h00) begin
      bad++; $display("FAIL async_reset_scancode: got %h want 00", scancode);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL async_reset_valid: got %b want 0", valid);
    end
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(20);
    send_bits(8'h23, 11, 1'b0, 1'b1, -1);
    wait_cyc(20);
    n   = codes.size() - base;
    got = (n > 0) ? codes[base] : 8'hxx;
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL post_reset_count: got %0d want 1", n);
    end
    total++;
    if (got !== 8'h23) begin
      bad++; $display("FAIL post_reset_code: got %h want 23", got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
